// File: rtl/rx_event_queue.sv
// rx_event_queue: turns receive-side frame, abort and line-loss indications
// into typed, sequence-numbered 8-bit events held in a small FIFO for the host.
// Optional statistics counters are built only when RX_EVENT_QUEUE_COUNTERS_EN
// is defined; otherwise the counter outputs are tied to zero.
module rx_event_queue #(
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_complete_in,
  input  logic                          frame_valid_in,
  input  logic                          abort_in,
  input  logic                          no_clock_in,
  input  logic                          status_ack,
  input  logic                          clear_in,
  output logic                          status_valid,
  output logic [7:0]                    status_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [COUNT_WIDTH-1:0]        good_count,
  output logic [COUNT_WIDTH-1:0]        bad_count,
  output logic [COUNT_WIDTH-1:0]        abort_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_L = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   ONE_L   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [1:0] TYPE_ABORT     = 2'b10;
  localparam logic [1:0] TYPE_LINE_LOSS = 2'b11;

  logic          no_clock_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   level;
  logic [5:0]    seq;
  logic [7:0]    head_q;
  logic [7:0]    mem [FIFO_DEPTH];

  logic          line_loss;
  logic          event_req;
  logic [1:0]    event_type;
  logic          lower_dropped;
  logic          full;
  logic          pop;
  logic          push;
  logic          full_drop;
  logic [7:0]    new_entry;
  logic [PW:0]   level_next;

  // Event detection, priority selection and FIFO push/pop decisions
  always_comb begin
    line_loss     = no_clock_in & ~no_clock_q;
    event_req     = line_loss | abort_in | frame_complete_in;
    event_type    = {1'b0, ~frame_valid_in};
    if (line_loss) begin
      event_type = TYPE_LINE_LOSS;
    end else if (abort_in) begin
      event_type = TYPE_ABORT;
    end
    lower_dropped = (line_loss & (abort_in | frame_complete_in)) |
                    (abort_in & frame_complete_in);
    full          = (level == DEPTH_L);
    pop           = status_ack & (level != '0);
    push          = event_req & (~full | pop);
    full_drop     = event_req & full & ~pop;
    new_entry     = {event_type, seq};
    level_next    = level;
    if (push && !pop) begin
      level_next = level + ONE_L;
    end else if (pop && !push) begin
      level_next = level - ONE_L;
    end
  end

  // Queue storage; stale slots are harmless because pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointers, occupancy, sequence number, registered head and line-state history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      no_clock_q <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      seq        <= '0;
      head_q     <= 8'h00;
    end else begin
      no_clock_q <= no_clock_in;
      level      <= level_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        seq    <= seq + 6'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && ((level == '0) || (pop && (level == ONE_L)))) begin
        head_q <= new_entry;
      end else if (pop && (level > ONE_L)) begin
        head_q <= mem[rd_ptr + PTR_ONE];
      end
    end
  end

  // Sticky loss flag; a new drop takes precedence over a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (lower_dropped || full_drop) begin
      overflow <= 1'b1;
    end else if (clear_in) begin
      overflow <= 1'b0;
    end
  end

  assign status_valid = (level != '0);
  assign status_data  = head_q;
  assign fifo_level   = level;

`ifdef RX_EVENT_QUEUE_COUNTERS_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  logic frame_good;
  logic frame_bad;

  assign frame_good = frame_complete_in & frame_valid_in;
  assign frame_bad  = frame_complete_in & ~frame_valid_in;

  // Saturating good-frame counter, counting detected events even if dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_count <= '0;
    end else if (clear_in) begin
      good_count <= '0;
    end else if (frame_good && (good_count != '1)) begin
      good_count <= good_count + CNT_ONE;
    end
  end

  // Saturating bad-frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_count <= '0;
    end else if (clear_in) begin
      bad_count <= '0;
    end else if (frame_bad && (bad_count != '1)) begin
      bad_count <= bad_count + CNT_ONE;
    end
  end

  // Saturating abort counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_count <= '0;
    end else if (clear_in) begin
      abort_count <= '0;
    end else if (abort_in && (abort_count != '1)) begin
      abort_count <= abort_count + CNT_ONE;
    end
  end
`else
  assign good_count  = '0;
  assign bad_count   = '0;
  assign abort_count = '0;
`endif

endmodule
